// File: rtl/decoder_2_to_4_pkg.sv
// decoder_2_to_4 shared constants and the pure 2-to-4 decode function.
// Internal codes are active-high one-hot; any polarity change happens at the top-level output.
package decoder_2_to_4_pkg;

  localparam int ADDR_W = 2;
  localparam int OUT_W  = 4;

  localparam logic [OUT_W-1:0] RST_CODE = 4'b0000;

  // Gate on enable before looking at the address, so an unknown address
  // cannot leak into the code while the decoder is disabled.
  function automatic logic [OUT_W-1:0] decode2to4(
    input logic              en,
    input logic [ADDR_W-1:0] addr
  );
    logic [OUT_W-1:0] v;
    v = RST_CODE;
    if (en) begin
      case (addr)
        2'd0:    v = 4'b0001;
        2'd1:    v = 4'b0010;
        2'd2:    v = 4'b0100;
        2'd3:    v = 4'b1000;
        default: v = RST_CODE;
      endcase
    end
    return v;
  endfunction

endpackage

// File: rtl/decoder_2_to_4.sv
// Registered 2-to-4 decoder with enable and selectable output polarity.
// Defining DECODER_2_TO_4_ONEHOT_CHK_EN compiles in simulation-only checks.
module decoder_2_to_4
  import decoder_2_to_4_pkg::*;
#(
  parameter logic OUT_ACTIVE = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic EN,
  input  logic A0,
  input  logic A1,
  output logic D0,
  output logic D1,
  output logic D2,
  output logic D3
);

  logic [ADDR_W-1:0] addr;
  logic [OUT_W-1:0]  nxt;
  logic [OUT_W-1:0]  q;
  logic [OUT_W-1:0]  d;

  assign addr = {A1, A0};
  assign nxt  = decode2to4(EN, addr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RST_CODE;
    end else begin
      q <= nxt;
    end
  end

  // Inactive level is ~OUT_ACTIVE, so reset and disabled codes invert too.
  assign d = OUT_ACTIVE ? q : ~q;

  assign {D3, D2, D1, D0} = d;

`ifdef DECODER_2_TO_4_ONEHOT_CHK_EN
  always @(posedge clk) begin
    if ($countones(q) > 1)
      $error("decoder_2_to_4: more than one output active (%b)", q);
    if (rst_n && EN && $isunknown(addr))
      $error("decoder_2_to_4: unknown address sampled with EN=1");
    if (!rst_n && q !== RST_CODE)
      $error("decoder_2_to_4: outputs active during reset (%b)", q);
  end
`endif

endmodule

// File: tb/tb_decoder_2_to_4.sv
// Directed testbench for decoder_2_to_4, checking both output polarities.
// Codes are written {D3,D2,D1,D0}; the inverted instance expects the complement.
module tb_decoder_2_to_4;

  logic clk;
  logic rst_n;
  logic EN;
  logic A0;
  logic A1;

  logic D0, D1, D2, D3;
  logic N0, N1, N2, N3;

  int tests;
  int fails;

  decoder_2_to_4 #(.OUT_ACTIVE(1'b1)) dut_hi (
    .clk   (clk),
    .rst_n (rst_n),
    .EN    (EN),
    .A0    (A0),
    .A1    (A1),
    .D0    (D0),
    .D1    (D1),
    .D2    (D2),
    .D3    (D3)
  );

  decoder_2_to_4 #(.OUT_ACTIVE(1'b0)) dut_lo (
    .clk   (clk),
    .rst_n (rst_n),
    .EN    (EN),
    .A0    (A0),
    .A1    (A1),
    .D0    (N0),
    .D1    (N1),
    .D2    (N2),
    .D3    (N3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] exp);
    logic [3:0] hi;
    logic [3:0] lo;
    logic [3:0] exp_lo;
    hi     = {D3, D2, D1, D0};
    lo     = {N3, N2, N1, N0};
    exp_lo = ~exp;
    tests++;
    assert (hi === exp)
    else begin
      fails++;
      $error("FAIL %s hi: observed %b expected %b", tag, hi, exp);
    end
    tests++;
    assert (lo === exp_lo)
    else begin
      fails++;
      $error("FAIL %s lo: observed %b expected %b", tag, lo, exp_lo);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests = 0;
    fails = 0;

    rst_n = 1'b0;
    EN    = 1'b1;
    A1    = 1'b1;
    A0    = 1'b1;
    #2;
    check("reset_async", 4'b0000);

    #1 rst_n = 1'b1;
    tick();
    check("reset_release", 4'b1000);

    EN = 1'b0; A1 = 1'bx; A0 = 1'bx;
    tick();
    check("disabled_x", 4'b0000);

    EN = 1'b1; A1 = 1'b0; A0 = 1'b0;
    tick();
    check("sweep_00", 4'b0001);

    A1 = 1'b0; A0 = 1'b1;
    tick();
    check("sweep_01", 4'b0010);

    #2 rst_n = 1'b0;
    #1;
    check("reset_mid", 4'b0000);
    #1 rst_n = 1'b1;
    #1;
    check("reset_hold", 4'b0000);
    tick();
    check("after_reset_01", 4'b0010);

    A1 = 1'b1; A0 = 1'b0;
    tick();
    check("sweep_10", 4'b0100);

    A1 = 1'b1; A0 = 1'b1;
    tick();
    check("sweep_11", 4'b1000);

    A1 = 1'b1; A0 = 1'b0;
    tick();
    check("drop_pre", 4'b0100);

    EN = 1'b0;
    tick();
    check("drop_en", 4'b0000);

    EN = 1'b1; A1 = 1'b1; A0 = 1'b1;
    tick();
    check("en_addr_same_edge", 4'b1000);

    A1 = 1'b0; A0 = 1'b0;
    tick();
    check("addr_11_to_00", 4'b0001);

    EN = 1'b0; A1 = 1'b0; A0 = 1'b1;
    tick();
    check("disabled_01", 4'b0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
